// File: rtl/core_boot_seq_pkg.sv
// core_boot_seq_pkg
//   Shared types and constants for the boot sequencer.
//   - boot_state_t     : sequencer state encoding
//   - INSTR_ECALL/EBREAK: instruction words that stop the core
//   - LAST_PRELOAD_REG : highest register index written during preload
//   - is_halt_instr()  : 1 when an instruction word should halt the core
// Optional feature macro used by the sequencer: BOOT_REG_PRELOAD_EN.
package core_boot_seq_pkg;

  typedef enum logic [2:0] {
    BOOT_IDLE      = 3'd0,
    BOOT_LOAD_IMEM = 3'd1,
    BOOT_LOAD_REGS = 3'd2,
    BOOT_RELEASE   = 3'd3,
    BOOT_RUN       = 3'd4,
    BOOT_HALT      = 3'd5
  } boot_state_t;

  localparam logic [31:0] INSTR_ECALL      = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK     = 32'h0010_0073;
  localparam logic [4:0]  LAST_PRELOAD_REG = 5'd31;

  function automatic logic is_halt_instr(input logic [31:0] inst);
    return (inst == INSTR_ECALL) || (inst == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/core_boot_seq_addr_gen.sv
// core_boot_seq_addr_gen
//   Program word counter for the instruction-memory load phase.
//   Produces the byte address of the next word to be written and flags
//   when the next accepted word occupies the final memory slot.
// Ports:
//   clk        in   core clock
//   rst_n      in   synchronous active-low reset
//   clr        in   restart counting from word 0
//   inc        in   one program word accepted this cycle
//   byte_addr  out  START_ADDR + 4*count (address for the word being accepted)
//   last_slot  out  count == IMEM_DEPTH-1 (the word being accepted fills memory)
module core_boot_seq_addr_gen
  import core_boot_seq_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] START_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] byte_addr,
  output logic        last_slot
);

  localparam int unsigned CW = $clog2(IMEM_DEPTH + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign byte_addr = START_ADDR + (32'(count) << 2);
  assign last_slot = (32'(count) == IMEM_DEPTH - 1);

endmodule

// File: rtl/core_boot_seq.sv
// core_boot_seq
//   Owns the s_core setup interface: streams a program into instruction
//   memory, optionally preloads x1..x31, lets the core load its PC, then
//   releases it. Freezes the core on ECALL/EBREAK and counts RUN cycles.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   i_start                       load request (IDLE/HALT only)
//   i_ld_valid/data/last, o_ld_ready  loader word stream
//   i_inst                        instruction currently executed by the core
//   o_setup                       1 = core frozen / in setup mode
//   o_imem_we, o_inst_mem_addr/data   program word write (1 cycle after handshake)
//   o_load_reg_addr/data          register preload write (addr 0 = no write)
//   o_pc_start_addr               PC start value
//   o_running, o_halted, o_err    status
//   o_cycles                      saturating count of RUN cycles
// Build option: define BOOT_REG_PRELOAD_EN to add the register preload phase;
//   otherwise o_load_reg_addr/data are tied to 0.
//
// state          | meaning
// BOOT_IDLE      | after reset, core frozen, waiting for i_start
// BOOT_LOAD_IMEM | accepting program words into instruction memory
// BOOT_LOAD_REGS | accepting register preload values x1, x2, ...
// BOOT_RELEASE   | single setup cycle so the PC loads o_pc_start_addr
// BOOT_RUN       | core running, cycle counter active
// BOOT_HALT      | ECALL/EBREAK seen or program overflow; core frozen
module core_boot_seq
  import core_boot_seq_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_ld_valid,
  input  logic [31:0]      i_ld_data,
  input  logic             i_ld_last,
  output logic             o_ld_ready,
  input  logic [31:0]      i_inst,
  output logic             o_setup,
  output logic             o_imem_we,
  output logic [31:0]      o_inst_mem_addr,
  output logic [31:0]      o_inst_mem_data,
  output logic [4:0]       o_load_reg_addr,
  output logic [31:0]      o_load_reg_data,
  output logic [31:0]      o_pc_start_addr,
  output logic             o_running,
  output logic             o_halted,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cycles
);

`ifdef BOOT_REG_PRELOAD_EN
  localparam boot_state_t IMEM_EXIT = BOOT_LOAD_REGS;
`else
  localparam boot_state_t IMEM_EXIT = BOOT_RELEASE;
`endif

  boot_state_t state;
  logic        hs;
  logic        start_ok;
  logic [31:0] next_addr;
  logic        last_slot;

  // Status outputs are plain decodes of the state register.
  assign o_ld_ready      = (state == BOOT_LOAD_IMEM) || (state == BOOT_LOAD_REGS);
  assign o_setup         = (state != BOOT_RUN);
  assign o_running       = (state == BOOT_RUN);
  assign o_halted        = (state == BOOT_HALT);
  assign o_pc_start_addr = START_ADDR;

  assign hs       = i_ld_valid & o_ld_ready;
  assign start_ok = i_start && ((state == BOOT_IDLE) || (state == BOOT_HALT));

  core_boot_seq_addr_gen #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .START_ADDR (START_ADDR)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .inc       (hs && (state == BOOT_LOAD_IMEM)),
    .byte_addr (next_addr),
    .last_slot (last_slot)
  );

`ifdef BOOT_REG_PRELOAD_EN
  logic [4:0] reg_idx;

  // Preload writes are one-cycle pulses: address 0 means "no write", which
  // is safe because x0 is never a preload target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_idx         <= 5'd1;
      o_load_reg_addr <= '0;
      o_load_reg_data <= '0;
    end else begin
      o_load_reg_addr <= '0;
      o_load_reg_data <= '0;
      if (state == BOOT_LOAD_IMEM) begin
        reg_idx <= 5'd1;
      end else if ((state == BOOT_LOAD_REGS) && hs) begin
        o_load_reg_addr <= reg_idx;
        o_load_reg_data <= i_ld_data;
        reg_idx         <= reg_idx + 5'd1;
      end
    end
  end
`else
  assign o_load_reg_addr = '0;
  assign o_load_reg_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= BOOT_IDLE;
      o_imem_we       <= 1'b0;
      o_inst_mem_addr <= '0;
      o_inst_mem_data <= '0;
      o_err           <= 1'b0;
      o_cycles        <= '0;
    end else begin
      o_imem_we <= 1'b0;
      case (state)
        BOOT_IDLE, BOOT_HALT: begin
          if (i_start) begin
            state    <= BOOT_LOAD_IMEM;
            o_err    <= 1'b0;
            o_cycles <= '0;
          end
        end
        BOOT_LOAD_IMEM: begin
          if (hs) begin
            o_imem_we       <= 1'b1;
            o_inst_mem_addr <= next_addr;
            o_inst_mem_data <= i_ld_data;
            if (i_ld_last) begin
              state <= IMEM_EXIT;
            end else if (last_slot) begin
              // Memory is now full and the loader still has more words.
              o_err <= 1'b1;
              state <= BOOT_HALT;
            end
          end
        end
`ifdef BOOT_REG_PRELOAD_EN
        BOOT_LOAD_REGS: begin
          if (hs && (i_ld_last || (reg_idx == LAST_PRELOAD_REG))) begin
            state <= BOOT_RELEASE;
          end
        end
`endif
        BOOT_RELEASE: begin
          state <= BOOT_RUN;
        end
        BOOT_RUN: begin
          if (o_cycles != {CNT_W{1'b1}}) begin
            o_cycles <= o_cycles + CNT_W'(1);
          end
          if (is_halt_instr(i_inst)) begin
            state <= BOOT_HALT;
          end
        end
        default: begin
          state <= BOOT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_boot_seq.sv
// tb_core_boot_seq
//   Randomized bench for core_boot_seq. Expected program/register writes are
//   queued from the words the bench offers (address = START + 4*index, register
//   index = position in the preload list); a negedge monitor compares every
//   write pulse and the invariant status outputs. Run-phase expectations come
//   from the number of RUN cycles before the halting instruction.
module tb_core_boot_seq;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] START  = 32'h0000_0040;
  localparam int unsigned CW     = 4;
  localparam int unsigned CMAX   = 15;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_ld_valid = 1'b0;
  logic [31:0]   i_ld_data = '0;
  logic          i_ld_last = 1'b0;
  logic [31:0]   i_inst = '0;
  logic          o_ld_ready, o_setup, o_imem_we, o_running, o_halted, o_err;
  logic [31:0]   o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_start_addr;
  logic [4:0]    o_load_reg_addr;
  logic [CW-1:0] o_cycles;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_addr[$], exp_data[$], wr_addr_log[$];
  logic [4:0]  exp_ridx[$], reg_addr_log[$];
  logic [31:0] exp_rdata[$], reg_data_log[$];

  core_boot_seq #(.IMEM_DEPTH(DEPTH), .START_ADDR(START), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ld_valid(i_ld_valid),
    .i_ld_data(i_ld_data), .i_ld_last(i_ld_last), .o_ld_ready(o_ld_ready),
    .i_inst(i_inst), .o_setup(o_setup), .o_imem_we(o_imem_we),
    .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data),
    .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data),
    .o_pc_start_addr(o_pc_start_addr), .o_running(o_running), .o_halted(o_halted),
    .o_err(o_err), .o_cycles(o_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] non_halt();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'h0020_0073;
      1:       v = 32'h0000_0013;
      default: v = $urandom;
    endcase
    if (v == ECALL || v == EBREAK) v = v ^ 32'h8000_0000;
    return v;
  endfunction

  // Monitor: every write pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      check("pc_start_addr", o_pc_start_addr, START);
      check("setup_iff_not_running", o_setup, !o_running);
      check("no_ready_in_run_halt", o_ld_ready & (o_running | o_halted), 0);
      if (o_imem_we) begin
        wr_addr_log.push_back(o_inst_mem_addr);
        check("imem_we_expected", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) begin
          check("imem_addr", o_inst_mem_addr, exp_addr.pop_front());
          check("imem_data", o_inst_mem_data, exp_data.pop_front());
        end
      end
`ifdef BOOT_REG_PRELOAD_EN
      if (o_load_reg_addr != 5'd0) begin
        reg_addr_log.push_back(o_load_reg_addr);
        reg_data_log.push_back(o_load_reg_data);
        check("reg_write_expected", exp_ridx.size() != 0, 1);
        if (exp_ridx.size() != 0) begin
          check("reg_addr", o_load_reg_addr, exp_ridx.pop_front());
          check("reg_data", o_load_reg_data, exp_rdata.pop_front());
        end
      end
`else
      check("load_reg_tied_zero", {o_load_reg_addr, o_load_reg_data}, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic offer_word(input logic [31:0] w, input bit last, output bit acc);
    int g = 0;
    i_ld_valid = 1'b1;
    i_ld_data  = w;
    i_ld_last  = last;
    while (!o_ld_ready && g < 8) begin
      tick();
      g++;
    end
    acc = o_ld_ready;
    tick();
    i_ld_valid = 1'b0;
    i_ld_last  = 1'b0;
    i_ld_data  = $urandom;
  endtask

  // Offers n program words; bub < 0 gives random bubbles between words.
  task automatic load_prog(input int n, input int bub, input bit with_last);
    bit acc;
    logic [31:0] w;
    wr_addr_log.delete();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        int nb = (bub < 0) ? int'($urandom_range(0, 2)) : bub;
        i_ld_valid = 1'b0;
        i_ld_last  = rbit();
        repeat (nb) tick();
        i_ld_last  = 1'b0;
      end
      w = $urandom;
      if (k < DEPTH) begin
        exp_addr.push_back(START + 32'(4 * k));
        exp_data.push_back(w);
      end
      offer_word(w, with_last && (k == n - 1), acc);
      check(k < DEPTH ? "word_accepted" : "overflow_word_refused", acc, k < DEPTH);
    end
  endtask

  task automatic load_regs(input int m, input bit with_last, input bit fixed);
    bit acc;
    logic [31:0] w;
    reg_addr_log.delete();
    reg_data_log.delete();
    for (int r = 1; r <= m; r++) begin
      w = fixed ? 32'hA + 32'(r - 1) : $urandom;
      exp_ridx.push_back(5'(r));
      exp_rdata.push_back(w);
      offer_word(w, with_last && (r == m), acc);
      check("reg_word_accepted", acc, 1);
    end
  endtask

  task automatic release_and_run(input int h, input logic [31:0] halt_code);
    int e;
    check("release_setup", o_setup, 1);
    check("release_not_running", o_running, 0);
    check("release_not_halted", o_halted, 0);
    tick();
    check("run_entered", o_running, 1);
    check("run_cycles_start", o_cycles, 0);
    check("writes_drained", exp_addr.size() + exp_ridx.size(), 0);
    for (int j = 1; j <= h; j++) begin
      i_inst     = (j == h) ? halt_code : non_halt();
      i_start    = ($urandom_range(0, 3) == 0);
      i_ld_valid = rbit();
      i_ld_last  = rbit();
      i_ld_data  = $urandom;
      tick();
      e = (j > int'(CMAX)) ? int'(CMAX) : j;
      check("run_cycles", o_cycles, 64'(e));
      check("run_running", o_running, j < h);
      check("run_halted", o_halted, j == h);
    end
    i_start = 1'b0;
    i_ld_last = 1'b0;
    e = (h > int'(CMAX)) ? int'(CMAX) : h;
    repeat (2) begin
      i_inst = $urandom;
      i_ld_valid = rbit();
      tick();
      check("halt_cycles_hold", o_cycles, 64'(e));
      check("halt_setup", o_setup, 1);
      check("halt_state", o_halted, 1);
      check("halt_no_err", o_err, 0);
    end
    i_ld_valid = 1'b0;
  endtask

  task automatic after_load(input int h, input logic [31:0] halt_code);
`ifdef BOOT_REG_PRELOAD_EN
    int m = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(1, 4));
    load_regs(m, (m < 31) ? 1'b1 : rbit(), 1'b0);
`endif
    release_and_run(h, halt_code);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_setup", o_setup, 1);
    check("rst_running", o_running, 0);
    check("rst_halted", o_halted, 0);
    check("rst_err", o_err, 0);
    check("rst_cycles", o_cycles, 0);
    check("rst_imem_we", o_imem_we, 0);
    check("rst_imem_addr", o_inst_mem_addr, 0);
    check("rst_imem_data", o_inst_mem_data, 0);
    check("rst_ready", o_ld_ready, 0);
    check("rst_reg_addr", o_load_reg_addr, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // IDLE ignores the loader.
    i_ld_valid = 1'b1;
    repeat (3) begin
      tick();
      check("idle_ready_low", o_ld_ready, 0);
    end
    i_ld_valid = 1'b0;

    // Three words back to back, EBREAK on the 5th RUN cycle.
    start_pulse();
    check("load_ready", o_ld_ready, 1);
    load_prog(3, 0, 1);
`ifdef BOOT_REG_PRELOAD_EN
    load_regs(1, 1'b1, 1'b0);
`endif
    release_and_run(5, EBREAK);
    check("A_write_count", wr_addr_log.size(), 3);
    if (wr_addr_log.size() == 3) begin
      check("A_addr0", wr_addr_log[0], 32'h40);
      check("A_addr2", wr_addr_log[2], 32'h48);
    end
    check("A_cycles", o_cycles, 5);

    // Valid 1,0,1: two words only, contiguous.
    start_pulse();
    load_prog(2, 1, 1);
    after_load(3, ECALL);
    check("B_write_count", wr_addr_log.size(), 2);
    if (wr_addr_log.size() == 2) check("B_addr1", wr_addr_log[1], 32'h44);

    // Overflow: six words, no last.
    start_pulse();
    load_prog(6, 0, 0);
    check("ovf_write_count", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4) check("ovf_addr3", wr_addr_log[3], 32'h4C);
    check("ovf_err", o_err, 1);
    check("ovf_halted", o_halted, 1);
    check("ovf_ready", o_ld_ready, 0);
    i_ld_valid = 1'b1;
    repeat (3) begin
      tick();
      check("ovf_err_sticky", o_err, 1);
    end
    i_ld_valid = 1'b0;
    start_pulse();
    check("restart_err_clear", o_err, 0);
    check("restart_ready", o_ld_ready, 1);
    // Exactly DEPTH words with last: fills memory without error.
    load_prog(DEPTH, -1, 1);
    after_load(18, ECALL);
    check("sat_cycles", o_cycles, 15);

    // Randomized programs and run lengths.
    for (int it = 0; it < 25; it++) begin
      int n;
      start_pulse();
      check("start_clears_err", o_err, 0);
      check("start_clears_cycles", o_cycles, 0);
      n = $urandom_range(1, 6);
      if (n <= int'(DEPTH)) begin
        load_prog(n, -1, 1);
        after_load($urandom_range(1, 20), rbit() ? ECALL : EBREAK);
      end else begin
        load_prog(n, -1, 0);
        check("rand_ovf_err", o_err, 1);
        check("rand_ovf_halted", o_halted, 1);
      end
    end

    // Reset from HALT with a nonzero cycle count.
    start_pulse();
    load_prog(1, 0, 1);
    after_load(7, EBREAK);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("halt_rst_cycles", o_cycles, 0);
    check("halt_rst_halted", o_halted, 0);
    check("halt_rst_setup", o_setup, 1);
    check("halt_rst_addr", o_inst_mem_addr, 0);

    // Reset in the middle of a program load.
    start_pulse();
    load_prog(2, 0, 0);
    i_ld_valid = 1'b1;
    i_ld_data  = $urandom;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_ready", o_ld_ready, 0);
    check("midrst_imem_we", o_imem_we, 0);
    check("midrst_err", o_err, 0);
    check("midrst_cycles", o_cycles, 0);
    check("midrst_data", o_inst_mem_data, 0);
    tick();
    check("midrst_idle_ready", o_ld_ready, 0);
    i_ld_valid = 1'b0;
    start_pulse();
    load_prog(2, -1, 1);
    after_load(3, ECALL);

`ifdef BOOT_REG_PRELOAD_EN
    // One program word, then x1=A, x2=B.
    start_pulse();
    load_prog(1, 0, 1);
    load_regs(2, 1'b1, 1'b1);
    check("pre_reg_count", reg_addr_log.size(), 2);
    if (reg_addr_log.size() == 2) begin
      check("pre_x1_addr", reg_addr_log[0], 1);
      check("pre_x1_data", reg_data_log[0], 32'hA);
      check("pre_x2_addr", reg_addr_log[1], 2);
      check("pre_x2_data", reg_data_log[1], 32'hB);
    end
    release_and_run(2, ECALL);
`endif

    tick();
    check("final_queues_empty", exp_addr.size() + exp_ridx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
